// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-wide AXI-Stream beat carrying one received UART character.
interface uart_rx_if;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, AXI-Stream output, framing and overrun pulses.
module uart_rx #(
  parameter int CLOCK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic      m_axis_aclk,
  input  logic      m_axis_areset,
  input  logic      rx_bit,
  uart_rx_if.master m_axis,
  output logic      frame_error,
  output logic      overrun
);
  localparam int UART_CYCLES = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_CYCLES = UART_CYCLES / 2;
  localparam int CW          = $clog2(UART_CYCLES);
  localparam logic [CW-1:0] BIT_LAST  = CW'(UART_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic          sync_q, sync_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d, fe_q, fe_d, ov_q, ov_d;
  logic          bit_end, half_end;
  always_comb begin
    sync_d    = rx_bit;
    rx_s_d    = sync_q;
    rx_prev_d = rx_s_q;
    bit_end   = cnt_q == BIT_LAST;
    half_end  = cnt_q == HALF_LAST;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tvalid_d  = tvalid_q && !m_axis.tready;
    tdata_d   = tdata_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: if (half_end) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d   = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) begin
        // Re-arm at mid-stop so a short stop bit does not swallow the next start edge.
        cnt_d   = '0;
        state_d = IDLE;
        if (!rx_s_q) fe_d = 1'b1;
        else if (!tvalid_q || m_axis.tready) begin
          tvalid_d = 1'b1;
          tdata_d  = shift_q;
        end else ov_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q   <= IDLE;
      sync_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign frame_error   = fe_q;
  assign overrun       = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 10 clocks per bit, checked against hand-computed beats and pulses.
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx_bit = 1'b1;
  logic frame_error, overrun;
  uart_rx_if axis ();
  uart_rx #(.CLOCK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000)) dut (
    .m_axis_aclk(clk), .m_axis_areset(rst), .rx_bit(rx_bit),
    .m_axis(axis), .frame_error(frame_error), .overrun(overrun));
  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic stop; int n_beats; logic [7:0] exp_data; int n_fe; } vec_t;
  vec_t vecs [4];
  int tests = 0, failed = 0, cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cycles = 0, rise_cyc = 0;
  int nb0, fe0, ov0, vc0, t0;
  logic prev_valid = 1'b0;
  logic [7:0] beats [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (axis.tvalid && axis.tready) beats.push_back(axis.tdata);
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_error && overrun) both_cnt++;
    if (axis.tvalid) valid_cycles++;
    if (axis.tvalid && !prev_valid) rise_cyc = cyc;
    prev_valid = axis.tvalid;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send_bit(input logic v);
    rx_bit = v;
    repeat (10) tick();
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask
  task automatic idle(input int n);
    rx_bit = 1'b1;
    repeat (n) tick();
  endtask
  task automatic snap();
    nb0 = beats.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cycles;
  endtask
  function automatic logic [7:0] beat(input int i);
    return (beats.size() > i) ? beats[i] : 8'hEE;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
    vecs[1] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[2] = '{8'hFE, 1'b1, 1, 8'hFE, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 8'hEE, 1};
    axis.tready = 1'b1;
    repeat (3) tick();
    check("reset_tvalid", axis.tvalid, 0);
    check("reset_tdata", axis.tdata, 0);
    check("reset_fe", frame_error, 0);
    check("reset_ov", overrun, 0);
    rst = 1'b0;
    idle(20);

    snap();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_beats", beats.size() - nb0, 1);
    check("a5_data", beat(nb0), 8'hA5);
    check("a5_valid_cycles", valid_cycles - vc0, 1);
    check("a5_latency", rise_cyc - t0, 98);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);

    for (int v = 0; v < 4; v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].stop);
      idle(20);
      check($sformatf("vec%0d_beats", v), beats.size() - nb0, vecs[v].n_beats);
      check($sformatf("vec%0d_data", v), beat(nb0), vecs[v].exp_data);
      check($sformatf("vec%0d_fe", v), fe_cnt - fe0, vecs[v].n_fe);
      check($sformatf("vec%0d_ov", v), ov_cnt - ov0, 0);
    end

    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(20);
    check("b2b_beats", beats.size() - nb0, 3);
    check("b2b_0", beat(nb0), 8'h00);
    check("b2b_1", beat(nb0 + 1), 8'hFF);
    check("b2b_2", beat(nb0 + 2), 8'h55);
    check("b2b_err", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    axis.tready = 1'b0;
    snap();
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(20);
    check("ovr_tvalid", axis.tvalid, 1);
    check("ovr_tdata", axis.tdata, 8'h12);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_fe", fe_cnt - fe0, 0);
    check("ovr_no_beat", beats.size() - nb0, 0);
    axis.tready = 1'b1;
    tick();
    axis.tready = 1'b0;
    check("ovr_drain_tvalid", axis.tvalid, 0);
    check("ovr_drain_beat", beat(nb0), 8'h12);
    check("ovr_drain_count", beats.size() - nb0, 1);
    axis.tready = 1'b1;
    idle(5);

    snap();
    rx_bit = 1'b0;
    repeat (3) tick();
    idle(30);
    check("glitch_valid", valid_cycles - vc0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("glitch_next", beat(nb0), 8'h3C);

    snap();
    send_frame(8'h3C, 1'b0);
    rx_bit = 1'b0;
    repeat (50) tick();
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_valid", valid_cycles - vc0, 0);
    idle(20);
    axis.tready = 1'b0;
    send_frame(8'h81, 1'b1);
    idle(20);
    check("ferr_next_valid", axis.tvalid, 1);
    check("ferr_next_data", axis.tdata, 8'h81);
    check("ferr_total", fe_cnt - fe0, 1);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rx_bit = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rst_async_tvalid", axis.tvalid, 0);
    check("rst_async_tdata", axis.tdata, 0);
    repeat (2) tick();
    rst = 1'b0;
    idle(120);
    check("rst_no_fe", fe_cnt - fe0, 0);
    check("rst_no_valid", axis.tvalid, 0);
    axis.tready = 1'b1;
    snap();
    send_frame(8'hC3, 1'b1);
    idle(20);
    check("rst_next_beats", beats.size() - nb0, 1);
    check("rst_next_data", beat(nb0), 8'hC3);
    check("rst_next_err", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
